// File: rtl/pix_stream_pkg.sv
// Shared types and default geometry for the pixel stream stages.
// Imported by the FIFO reader and the downstream filter blocks.
package pix_stream_pkg;

  localparam int unsigned DEF_IMG_W  = 640;
  localparam int unsigned DEF_IMG_H  = 480;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_X_W    = $clog2(DEF_IMG_W);
  localparam int unsigned DEF_Y_W    = $clog2(DEF_IMG_H);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_X_W-1:0]    x;
    logic [DEF_Y_W-1:0]    y;
    logic                  sof;
    logic                  eol;
    logic                  eof;
  } pix_beat_t;

  // A read may issue only if every in-flight and buffered pixel still has a slot.
  function automatic logic rd_allowed(input logic [1:0] cnt, input logic pend, input logic pop);
    return (3'(cnt) + 3'(pend)) < (3'd2 + 3'(pop));
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; head is always entry 0.
// Push and pop in the same cycle keep occupancy and ordering intact.
module skid_buf2 #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [1:0]   o_cnt,
  output logic [W-1:0] o_head
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= 2'd0;
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem0 <= i_data;
          else               r_mem1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Full: shift then append; single entry: replace head directly.
          if (r_cnt == 2'd2) begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end else begin
            r_mem0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cnt  = r_cnt;
  assign o_head = r_mem0;

endmodule

// File: rtl/fifo_pixel_reader.sv
// Reads one IMG_W*IMG_H frame from the pixel FIFO per start and emits it as a
// valid/ready raster stream with coordinates and frame/line markers.
module fifo_pixel_reader
  import pix_stream_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_frame_done,
  input  logic                       i_fifo_empty,
  input  logic [DATA_W-1:0]          i_fifo_data,
  output logic                       o_fifo_rd,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic [DATA_W-1:0]          o_m_data,
  output logic [$clog2(IMG_W)-1:0]   o_m_x,
  output logic [$clog2(IMG_H)-1:0]   o_m_y,
  output logic                       o_m_sof,
  output logic                       o_m_eof,
  output logic                       o_m_eol
);

  localparam int unsigned XW   = $clog2(IMG_W);
  localparam int unsigned YW   = $clog2(IMG_H);
  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = $clog2(NPIX + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_rd_cnt;
  logic          r_pend;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_busy;
  logic          r_frame_done;

  logic [1:0]    w_cnt;
  logic          w_pop;
  logic          w_fifo_rd;
  logic          w_last_rd;
  logic          w_frame_end;
  logic          w_eol;
  logic          w_eof;

  skid_buf2 #(.W(DATA_W)) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (r_pend),
    .i_data (i_fifo_data),
    .i_pop  (w_pop),
    .o_cnt  (w_cnt),
    .o_head (o_m_data)
  );

  assign o_m_valid = (w_cnt != 2'd0);
  assign w_pop     = o_m_valid && i_m_ready;

  // Head-of-stream markers decoded from the coordinate counters.
  assign w_eol   = (r_x == XW'(IMG_W - 1));
  assign w_eof   = w_eol && (r_y == YW'(IMG_H - 1));
  assign o_m_x   = r_x;
  assign o_m_y   = r_y;
  assign o_m_eol = w_eol;
  assign o_m_eof = w_eof;
  assign o_m_sof = (r_x == '0) && (r_y == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Read strobe is combinational so a pop can free a slot in the same cycle.
  always_comb begin
    w_fifo_rd   = 1'b0;
    w_last_rd   = 1'b0;
    w_frame_end = 1'b0;
    if ((r_state == STREAM) && !i_fifo_empty && (r_rd_cnt < CW'(NPIX)) &&
        rd_allowed(w_cnt, r_pend, w_pop)) begin
      w_fifo_rd = 1'b1;
    end
    w_last_rd   = w_fifo_rd && (r_rd_cnt == CW'(NPIX - 1));
    w_frame_end = (r_state == DRAIN) && w_pop && w_eof;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_start && !r_frame_done) w_state_nxt = STREAM;
      STREAM:  if (w_last_rd) w_state_nxt = DRAIN;
      DRAIN:   if (w_frame_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_cnt     <= '0;
      r_pend       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_pend       <= w_fifo_rd;
      r_busy       <= (w_state_nxt != IDLE);
      r_frame_done <= w_frame_end;
      if ((r_state == IDLE) && (w_state_nxt == STREAM)) r_rd_cnt <= '0;
      else if (w_fifo_rd)                                r_rd_cnt <= r_rd_cnt + CW'(1);
    end
  end

  // Raster coordinates of the head pixel advance on every handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (w_eol) begin
        r_x <= '0;
        if (r_y == YW'(IMG_H - 1)) r_y <= '0;
        else                       r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign o_fifo_rd    = w_fifo_rd;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Directed bench for fifo_pixel_reader with a 4x2 frame and a behavioural FIFO
// that returns data one cycle after the read strobe.
module tb_fifo_pixel_reader;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned DW = 8;

  logic       clk = 1'b0;
  logic       rst, start, m_ready, hold;
  logic       fifo_empty, fifo_rd;
  logic [7:0] fifo_data = 8'h00;
  logic       busy, frame_done, m_valid, sof, eof, eol;
  logic [7:0] m_data;
  logic [1:0] m_x;
  logic [0:0] m_y;

  always #5 clk = ~clk;

  fifo_pixel_reader #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_frame_done(frame_done),
    .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data), .o_fifo_rd(fifo_rd),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_x(m_x), .o_m_y(m_y),
    .o_m_sof(sof), .o_m_eof(eof), .o_m_eol(eol)
  );

  logic [7:0]  mem [256];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  assign fifo_empty = hold || (rd_ptr == wr_ptr);

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_total, rd_first, fd_cnt, hold_viol, cnt_viol, full_rd_viol;
  bit          saw_full;
  bit          prev_stall = 1'b0;
  logic [13:0] prev_b;
  logic [13:0] cur_b;
  logic [13:0] cap_b [$];
  int          cap_cyc [$];
  logic [5:0]  pat = 6'b101001;

  assign cur_b = {m_data, m_x, m_y, sof, eol, eof};

  // FIFO model plus stream monitors.
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
    if (!rst) begin
      if (fifo_rd) begin
        rd_total++;
        if (rd_first < 0) rd_first = cyc;
      end
      if (m_valid && m_ready) begin
        cap_b.push_back(cur_b);
        cap_cyc.push_back(cyc);
      end
      if (prev_stall && (!m_valid || cur_b != prev_b)) hold_viol++;
      if (dut.u_skid.o_cnt > 2'd2) cnt_viol++;
      if (dut.u_skid.o_cnt == 2'd2) saw_full = 1'b1;
      if (fifo_rd && dut.u_skid.o_cnt == 2'd2 && !m_ready) full_rd_viol++;
      if (frame_done) fd_cnt++;
    end
    prev_stall = m_valid && !m_ready && !rst;
    prev_b     = cur_b;
    cyc++;
  end

  function automatic logic [13:0] exp_beat(input int i, input logic [7:0] base);
    logic [7:0] d;
    logic [1:0] x;
    logic       y;
    d = base + 8'(i);
    x = 2'(i % 4);
    y = 1'(i / 4);
    return {d, x, y, (i == 0), (x == 2'd3), (i == 7)};
  endfunction

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic clr_mon();
    rd_total = 0; rd_first = -1; fd_cnt = 0;
    hold_viol = 0; cnt_viol = 0; full_rd_viol = 0; saw_full = 1'b0;
    cap_b.delete(); cap_cyc.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns at the negedge where frame_done is seen; mode 1 drives the ready pattern.
  task automatic wait_done(input int max, input int mode);
    bit got = 1'b0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clk);
      if (mode == 1) m_ready = pat[k % 6];
      if (frame_done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_done timeout got no frame_done within %0d cycles", max);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b1; hold = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got %b exp 0", m_valid); end
    checks++; if (fifo_rd !== 1'b0)    begin errors++; $display("FAIL rst_rd got %b exp 0", fifo_rd); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
    checks++; if ({m_data, m_x, m_y} !== 11'd0) begin errors++; $display("FAIL rst_data got %h exp 0", {m_data, m_x, m_y}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clr_mon();
    for (int v = 0; v < 8; v++) push(8'(v));
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_pre got %b exp 0", busy); end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b exp 1", busy); end
    wait_done(60, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b exp 0", busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (cap_b.size() != 8) begin errors++; $display("FAIL basic_count got %0d exp 8", cap_b.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (cap_b[k] !== exp_beat(k, 8'h00)) begin errors++; $display("FAIL basic_beat%0d got %h exp %h", k, cap_b[k], exp_beat(k, 8'h00)); end
      end
      checks++; if (cap_cyc[0] != rd_first + 2) begin errors++; $display("FAIL basic_latency got %0d exp %0d", cap_cyc[0], rd_first + 2); end
      checks++; if (cap_cyc[7] - cap_cyc[0] != 7) begin errors++; $display("FAIL basic_rate got %0d exp 7", cap_cyc[7] - cap_cyc[0]); end
    end
    checks++; if (rd_total != 8) begin errors++; $display("FAIL basic_reads got %0d exp 8", rd_total); end
    checks++; if (fd_cnt != 1)   begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_two_frames();
    clr_mon();
    for (int v = 0; v < 16; v++) push(8'(v));
    start_pulse();
    wait_done(60, 0);
    repeat (3) @(negedge clk);
    checks++; if (rd_total != 8) begin errors++; $display("FAIL two_reads1 got %0d exp 8", rd_total); end
    checks++; if (wr_ptr - rd_ptr != 8) begin errors++; $display("FAIL two_left got %0d exp 8", wr_ptr - rd_ptr); end
    checks++;
    if (cap_b.size() != 8) begin errors++; $display("FAIL two_count1 got %0d exp 8", cap_b.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_b[k] !== exp_beat(k, 8'h00)) begin errors++; $display("FAIL two_f1_beat%0d got %h exp %h", k, cap_b[k], exp_beat(k, 8'h00)); end
    end
    clr_mon();
    start_pulse();
    wait_done(60, 0);
    repeat (3) @(negedge clk);
    checks++; if (rd_total != 8) begin errors++; $display("FAIL two_reads2 got %0d exp 8", rd_total); end
    checks++;
    if (cap_b.size() != 8) begin errors++; $display("FAIL two_count2 got %0d exp 8", cap_b.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_b[k] !== exp_beat(k, 8'h08)) begin errors++; $display("FAIL two_f2_beat%0d got %h exp %h", k, cap_b[k], exp_beat(k, 8'h08)); end
    end
  endtask

  task automatic test_backpressure();
    clr_mon();
    for (int v = 0; v < 8; v++) push(8'(8'h40 + v));
    start_pulse();
    wait_done(200, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (cap_b.size() != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", cap_b.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_b[k] !== exp_beat(k, 8'h40)) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", k, cap_b[k], exp_beat(k, 8'h40)); end
    end
    checks++; if (hold_viol != 0)    begin errors++; $display("FAIL bp_hold got %0d exp 0", hold_viol); end
    checks++; if (cnt_viol != 0)     begin errors++; $display("FAIL bp_cnt got %0d exp 0", cnt_viol); end
    checks++; if (full_rd_viol != 0) begin errors++; $display("FAIL bp_full_rd got %0d exp 0", full_rd_viol); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_saw_full got %b exp 1", saw_full); end
    checks++; if (rd_total != 8)     begin errors++; $display("FAIL bp_reads got %0d exp 8", rd_total); end
  endtask

  task automatic test_empty_gap();
    clr_mon();
    for (int v = 0; v < 3; v++) push(8'(v));
    start_pulse();
    for (int k = 0; k < 40 && cap_b.size() < 3; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy%0d got %b exp 1", k, busy); end
    end
    for (int v = 3; v < 8; v++) push(8'(v));
    wait_done(60, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (cap_b.size() != 8) begin errors++; $display("FAIL gap_count got %0d exp 8", cap_b.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (cap_b[k] !== exp_beat(k, 8'h00)) begin errors++; $display("FAIL gap_beat%0d got %h exp %h", k, cap_b[k], exp_beat(k, 8'h00)); end
      end
      checks++; if (cap_cyc[3] - cap_cyc[2] != 8) begin errors++; $display("FAIL gap_pause got %0d exp 8", cap_cyc[3] - cap_cyc[2]); end
      checks++; if (cap_cyc[7] - cap_cyc[3] != 4) begin errors++; $display("FAIL gap_resume got %0d exp 4", cap_cyc[7] - cap_cyc[3]); end
    end
  endtask

  task automatic test_mid_reset();
    clr_mon();
    for (int v = 0; v < 8; v++) push(8'(v));
    start_pulse();
    for (int k = 0; k < 40 && cap_b.size() < 5; k++) @(negedge clk);
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h05) begin errors++; $display("FAIL mr_head got %b/%h exp 1/05", m_valid, m_data); end
    checks++; if (dut.u_skid.o_cnt !== 2'd2) begin errors++; $display("FAIL mr_buffered got %0d exp 2", dut.u_skid.o_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", m_valid); end
    checks++; if ({m_data, m_x, m_y} !== 11'd0) begin errors++; $display("FAIL mr_outs got %h exp 0", {m_data, m_x, m_y}); end
    checks++; if (busy !== 1'b0 || fifo_rd !== 1'b0) begin errors++; $display("FAIL mr_ctl got %b%b exp 00", busy, fifo_rd); end
    rst = 1'b0;
    wr_ptr = rd_ptr;
    clr_mon();
    for (int v = 0; v < 8; v++) push(8'(8'h20 + v));
    m_ready = 1'b1;
    start_pulse();
    wait_done(60, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (cap_b.size() != 8) begin errors++; $display("FAIL mr_count got %0d exp 8", cap_b.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_b[k] !== exp_beat(k, 8'h20)) begin errors++; $display("FAIL mr_beat%0d got %h exp %h", k, cap_b[k], exp_beat(k, 8'h20)); end
    end
  endtask

  task automatic test_start_ignored();
    clr_mon();
    for (int v = 0; v < 16; v++) push(8'(8'h60 + v));
    start_pulse();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(60, 0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL si_busy got %b exp 0", busy); end
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL si_busy_late got %b exp 0", busy); end
    checks++; if (rd_total != 8)        begin errors++; $display("FAIL si_reads got %0d exp 8", rd_total); end
    checks++; if (fd_cnt != 1)          begin errors++; $display("FAIL si_done_cnt got %0d exp 1", fd_cnt); end
    checks++; if (wr_ptr - rd_ptr != 8) begin errors++; $display("FAIL si_left got %0d exp 8", wr_ptr - rd_ptr); end
    checks++;
    if (cap_b.size() != 8) begin errors++; $display("FAIL si_count got %0d exp 8", cap_b.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_b[k] !== exp_beat(k, 8'h60)) begin errors++; $display("FAIL si_beat%0d got %h exp %h", k, cap_b[k], exp_beat(k, 8'h60)); end
    end
    wr_ptr = rd_ptr;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_frames();
    test_backpressure();
    test_empty_gap();
    test_mid_reset();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pixel_reader.md
# fifo_pixel_reader

Drains 8-bit pixels from the input FIFO and presents them as a valid/ready raster stream with x/y coordinates and frame/line markers. It sits directly downstream of the pixel FIFO and feeds the filter stages. It absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer. It reads exactly one frame of IMG_W*IMG_H pixels per `start`, so it never over-reads into the next frame.

## Interface
- `IMG_W`, 640, pixels per line (≥2)
- `IMG_H`, 480, lines per frame (≥2)
- `DATA_W`, 8, pixel width; matches FIFO data width
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse, arms one frame
- `busy` out 1: high from accepted `start` until the last pixel is handed off
- `frame_done` out 1: one-cycle pulse after the last pixel handshake
- `fifo_empty` in 1: FIFO empty flag
- `fifo_data` in DATA_W: FIFO read data, valid the cycle after `fifo_rd`
- `fifo_rd` out 1: FIFO read strobe
- `m_valid` out 1: output pixel valid
- `m_ready` in 1: downstream accept
- `m_data` out DATA_W: pixel
- `m_x` out $clog2(IMG_W): column of `m_data`
- `m_y` out $clog2(IMG_H): row of `m_data`
- `m_sof` / `m_eof` out 1: pixel is (0,0) / (IMG_W-1, IMG_H-1)
- `m_eol` out 1: pixel is at x = IMG_W-1

## Operation
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE → STREAM on `start`. The read counter is cleared.
  - STREAM → DRAIN in the cycle the IMG_W*IMG_H-th `fifo_rd` issues.
  - DRAIN → IDLE on the handshake of the `m_eof` pixel. `frame_done` pulses in that same transition cycle.
- `start` is ignored in STREAM and DRAIN.
- Read issue rule: `fifo_rd` = STREAM && !fifo_empty && (cnt + pend − pop) < 2.
  - `cnt` is skid-buffer occupancy (0..2).
  - `pend` is a read issued last cycle.
  - `pop` = m_valid && m_ready.
- `pend` = registered `fifo_rd`. When `pend` is set, `fifo_data` is written into the skid buffer.
- The skid buffer is a 2-entry FIFO. Head is output: `m_valid` = (cnt != 0), `m_data` = head.
- Buffer overflow is impossible by construction. Verification asserts cnt ≤ 2 at all times.
- Coordinates advance on each pop:
  - x increments.
  - At IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), both wrap to 0.
- Markers are combinational decodes of x/y at the head.
- Read counter width is $clog2(IMG_W*IMG_H+1). It saturates at IMG_W*IMG_H; no further reads are issued.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `frame_done`=0, `fifo_rd`=0, `m_valid`=0
  - `m_data`=0, `m_x`=0, `m_y`=0
  - cnt=0, pend=0, read counter=0
- Latency: `fifo_rd` at cycle n → pixel is `m_valid` at n+2 (data lands in n+1, registered into the buffer).
- Throughput: 1 pixel/cycle sustained when the FIFO is non-empty and `m_ready`=1.
  - There is a combinational path `m_ready` → `fifo_rd`; this is intended.
- Stream rules:
  - `m_data`, `m_x`, `m_y` and all markers are held stable while `m_valid` && !`m_ready`.
  - `m_valid` never drops without a handshake.
- `busy` rises the cycle after `start`. It falls the cycle after the `m_eof` handshake, in step with the `frame_done` pulse.
- Empty FIFO mid-frame: reads stall, with no bubbles beyond the FIFO's own gaps.
- `fifo_empty` rising in the cycle after a read does not cancel `pend`.
- Simultaneous write and pop on the buffer: occupancy is unchanged and order is preserved.
- Reset mid-frame:
  - all state is cleared and buffered pixels are discarded;
  - a byte in flight from the FIFO is dropped.
  - Upstream must also reset to stay frame-aligned.
- A `start` arriving in the same cycle as `frame_done` is ignored. A new frame needs `start` in IDLE.

## Structure
- Package `pix_stream_pkg` holds:
  - `state_t` enum {IDLE, STREAM, DRAIN};
  - `pix_beat_t` struct {data, x, y, sof, eol, eof};
  - default IMG_W/IMG_H/DATA_W localparams shared with the filter stages.
- Sub-module `skid_buf2`: parameterised 2-entry buffer with push/pop/cnt/head. Reused later by other stream stages.
- Top holds the FSM, read counter, `pend` register and x/y counters.

## Test plan
Bench uses IMG_W=4, IMG_H=2.
- Reset then `start`, FIFO preloaded with 0x00..0x07, `m_ready`=1:
  - 8 beats on consecutive cycles, first beat 2 cycles after the first `fifo_rd`;
  - sof on 0x00, eol on 0x03 and 0x07, eof on 0x07;
  - `frame_done` pulses once, exactly 8 reads issued.
- Same preload plus 0x08..0x0F, one `start`: only 0x00..0x07 are read; FIFO retains 8 entries; a second `start` streams 0x08..0x0F with x/y restarting at (0,0).
- `m_ready` toggled 1,0,0,1,0,1…: outputs hold during stalls, no loss or duplication, cnt never exceeds 2, `fifo_rd` suppressed while the buffer is full.
- FIFO empty after 3 pixels for 5 cycles, then refilled: stream pauses at x=3,y=0 boundary correctly, resumes with 0x03, `busy` stays high throughout.
- `rst` asserted at beat 0x05 with 2 pixels buffered: next cycle all outputs are at reset values; a later `start` begins at (0,0).
- `start` pulsed in STREAM and in the `frame_done` cycle: ignored, with no extra reads or state change.
